// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - requester and serializer handshake bundle for uart_tx_arb
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ack_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 busy_o;
  logic [7:0]           tx_data_o;
  logic                 tx_start_o;
  logic                 tx_ready_i;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ack_o, grant_o, busy_o, tx_data_o, tx_start_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ack_o, grant_o, busy_o, tx_data_o, tx_start_o
  );
endinterface

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin message-locked arbiter feeding one uart_tx serializer
module uart_tx_arb #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.master bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_LOW  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   owner_next;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W:0]     cand;
  logic               pick_found;
  logic [15:0]        tmo_q, tmo_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q;
  logic [7:0]         data_q, data_d;
  logic               start_q;
  logic               owner_valid;
  logic               owner_last;
  logic [7:0]         owner_data;

  // Mux out the current owner's request lines.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_valid = bus.req_valid_i[i];
        owner_last  = bus.req_last_i[i];
        owner_data  = bus.req_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    if (owner_q == PTR_W'(NUM_REQ - 1)) owner_next = '0;
    else                                owner_next = owner_q + 1'b1;
  end

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!pick_found && bus.req_valid_i[cand[PTR_W-1:0]]) begin
        pick       = cand[PTR_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    tmo_d    = tmo_q;
    last_d   = last_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d = pick;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          tmo_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (owner_valid) begin
          tmo_d = '0;
          if (bus.tx_ready_i) begin
            data_d  = owner_data;
            last_d  = owner_last;
            state_d = ST_START;
          end
        end else begin
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          // An owner that goes silent mid-message must not starve everyone else.
          if (LOCK_TIMEOUT != 0 && ({1'b0, tmo_q} + 17'd1) == 17'(LOCK_TIMEOUT)) begin
            tmo_d    = '0;
            grant_d  = '0;
            rr_ptr_d = owner_next;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_START:    state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.tx_ready_i) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = owner_next;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Start and ack are flopped from the next state so neither sees tx_ready_i combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      tmo_q    <= '0;
      last_q   <= 1'b0;
      data_q   <= 8'h00;
      start_q  <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      tmo_q    <= tmo_d;
      last_q   <= last_d;
      data_q   <= data_d;
      start_q  <= (state_d == ST_START);
      ack_q    <= (state_d == ST_START) ? grant_d : '0;
    end
  end

  assign bus.grant_o    = grant_q;
  assign bus.req_ack_o  = ack_q;
  assign bus.tx_start_o = start_q;
  assign bus.tx_data_o  = data_q;
  assign bus.busy_o     = (state_q != ST_IDLE);
endmodule
